// File: rtl/regdst_pipe_if.sv
// regdst_pipe_if: bundles the selector inputs, queries and per-stage outputs of regdst_pipe
//   master: drives sel, in_bus, in_valid, stall, flush, query_a, query_b; observes the rest
//   slave : the pipeline itself; drives stage_dest, stage_valid, out_dest, out_valid, hit_a, hit_b
interface regdst_pipe_if #(
  parameter int W     = 5,
  parameter int N     = 3,
  parameter int DEPTH = 3
);
  localparam int SW = $clog2(N);
  logic [SW-1:0]      sel;
  logic [N*W-1:0]     in_bus;
  logic               in_valid;
  logic               stall;
  logic               flush;
  logic [W-1:0]       query_a;
  logic [W-1:0]       query_b;
  logic [DEPTH*W-1:0] stage_dest;
  logic [DEPTH-1:0]   stage_valid;
  logic [W-1:0]       out_dest;
  logic               out_valid;
  logic [DEPTH-1:0]   hit_a;
  logic [DEPTH-1:0]   hit_b;
  modport master (
    output sel, in_bus, in_valid, stall, flush, query_a, query_b,
    input  stage_dest, stage_valid, out_dest, out_valid, hit_a, hit_b
  );
  modport slave (
    input  sel, in_bus, in_valid, stall, flush, query_a, query_b,
    output stage_dest, stage_valid, out_dest, out_valid, hit_a, hit_b
  );
endinterface

// File: rtl/regdst_pipe.sv
// regdst_pipe: selects one of N destination fields and tracks it with a write-valid through DEPTH stages
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; clears every stage
//   bus.sel      binary channel select; sel >= N launches dest 0 with valid 0
//   bus.in_bus   N candidate fields, channel i at [i*W +: W]
//   bus.in_valid launched instruction writes a register
//   bus.stall    hold all stages (input ignored)
//   bus.flush    clear every stage valid at the next edge, overrides stall
//   bus.query_a/b source addresses compared against every stage
//   bus.stage_dest/stage_valid  all stages, stage s at slot s-1
//   bus.out_dest/out_valid      last stage
//   bus.hit_a/hit_b             per-stage valid address match
// Optional ZERO_SUPPRESS_EN: register 0 is never tracked and never reported as a hit.
module regdst_pipe #(
  parameter int W     = 5,
  parameter int N     = 3,
  parameter int DEPTH = 3
) (
  input logic         clk,
  input logic         rst_n,
  regdst_pipe_if.slave bus
);
  localparam int SW = $clog2(N);
  // channel table padded to a power of two so any sel value indexes in range; padding reads 0
  logic [W-1:0] ch [2**SW];
  for (genvar i = 0; i < 2**SW; i++) begin : g_ch
    if (i < N) begin : g_in
      assign ch[i] = bus.in_bus[i*W +: W];
    end else begin : g_pad
      assign ch[i] = '0;
    end
  end
  logic                    sel_ok;
  logic [W-1:0]            sel_dest;
  logic                    launch_v;
  logic                    adv;
  logic [DEPTH-1:0][W-1:0] dest_q, dest_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0]        hit_a_w, hit_b_w;
  logic                    qa_ok, qb_ok;
  assign sel_ok   = {1'b0, bus.sel} < (SW+1)'(N);
  assign sel_dest = ch[bus.sel];
`ifdef ZERO_SUPPRESS_EN
  assign launch_v = bus.in_valid & sel_ok & (|sel_dest);
  assign qa_ok    = |bus.query_a;
  assign qb_ok    = |bus.query_b;
`else
  assign launch_v = bus.in_valid & sel_ok;
  assign qa_ok    = 1'b1;
  assign qb_ok    = 1'b1;
`endif
  // flush must still clock the stages even while stalled
  assign adv = bus.flush | ~bus.stall;
  always_comb begin
    dest_d  = dest_q;
    valid_d = valid_q;
    if (adv) begin
      dest_d[0]  = sel_dest;
      valid_d[0] = launch_v;
      for (int s = 1; s < DEPTH; s++) begin
        dest_d[s]  = dest_q[s-1];
        valid_d[s] = valid_q[s-1];
      end
    end
    if (bus.flush) valid_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q  <= '0;
      valid_q <= '0;
    end else begin
      dest_q  <= dest_d;
      valid_q <= valid_d;
    end
  end
  always_comb begin
    hit_a_w = '0;
    hit_b_w = '0;
    for (int s = 0; s < DEPTH; s++) begin
      hit_a_w[s] = valid_q[s] & qa_ok & (dest_q[s] == bus.query_a);
      hit_b_w[s] = valid_q[s] & qb_ok & (dest_q[s] == bus.query_b);
    end
  end
  assign bus.stage_dest  = dest_q;
  assign bus.stage_valid = valid_q;
  assign bus.out_dest    = dest_q[DEPTH-1];
  assign bus.out_valid   = valid_q[DEPTH-1];
  assign bus.hit_a       = hit_a_w;
  assign bus.hit_b       = hit_b_w;
endmodule
